// File: rtl/vc_wrr_scheduler.sv
// ---------------------------------------------------------------------------
// vc_wrr_scheduler
//   Weighted round-robin scheduler sharing one output link between the VC0 and
//   VC1 show-ahead FIFOs. It issues at most one pop per cycle, stops popping
//   while either destination FIFO is almost full, and forwards the popped head
//   word to data_out one cycle later. Weights are loaded while in INIT.
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   reset_L         in   synchronous reset, active-low
//   init            in   request configuration (enter/stay in INIT)
//   cfg_weight_vc0  in   VC0 weight, latched every cycle spent in INIT
//   cfg_weight_vc1  in   VC1 weight, latched every cycle spent in INIT
//   vc0_empty       in   VC0 FIFO empty
//   vc1_empty       in   VC1 FIFO empty
//   vc0_data        in   VC0 head word (valid while !vc0_empty)
//   vc1_data        in   VC1 head word (valid while !vc1_empty)
//   pause_d0        in   destination D0 almost full
//   pause_d1        in   destination D1 almost full
//   pop_vc0         out  pop VC0 (combinational)
//   pop_vc1         out  pop VC1 (combinational)
//   data_out        out  word popped on the previous cycle (registered)
//   valid_out       out  data_out valid (registered)
//   state           out  RESET=00 INIT=01 IDLE=10 ACTIVE=11
// ---------------------------------------------------------------------------
module vc_wrr_scheduler #(
    parameter int DATA_WIDTH = 6,
    parameter int W_WIDTH    = 4,
    parameter int W_DEFAULT  = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic [W_WIDTH-1:0]    cfg_weight_vc0,
    input  logic [W_WIDTH-1:0]    cfg_weight_vc1,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  pause_d0,
    input  logic                  pause_d1,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_t;

    localparam logic [W_WIDTH-1:0] W_DEF = W_WIDTH'(W_DEFAULT);

    state_t               state_q;
    state_t               state_n;
    logic [W_WIDTH-1:0]   weight_vc0;
    logic [W_WIDTH-1:0]   weight_vc1;
    logic [W_WIDTH-1:0]   credit;
    logic [W_WIDTH-1:0]   credit_n;
    logic [W_WIDTH:0]     credit_inc;
    logic [W_WIDTH-1:0]   weight_cur;
    logic                 cur_vc;
    logic                 cur_vc_n;
    logic                 pause;
    logic                 serve;

    // A zero weight still grants one word per turn.
    function automatic logic [W_WIDTH-1:0] eff_weight(input logic [W_WIDTH-1:0] w);
        return (w == '0) ? W_WIDTH'(1) : w;
    endfunction

    assign state      = state_q;
    assign pause      = pause_d0 | pause_d1;
    assign serve      = (state_q == ST_ACTIVE) && !init && !pause;
    // One extra bit so the compare against the weight can never wrap.
    assign credit_inc = {1'b0, credit} + (W_WIDTH+1)'(1);

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_RESET: state_n = ST_INIT;
            ST_INIT: begin
                if (!init) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (init)                         state_n = ST_INIT;
                else if (!vc0_empty || !vc1_empty) state_n = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // A paused link holds state even if both VCs ran dry.
                if (init)                                  state_n = ST_INIT;
                else if (!pause && vc0_empty && vc1_empty) state_n = ST_IDLE;
            end
            default: state_n = ST_RESET;
        endcase
    end

    always_comb begin
        pop_vc0    = 1'b0;
        pop_vc1    = 1'b0;
        cur_vc_n   = cur_vc;
        credit_n   = credit;
        weight_cur = cur_vc ? weight_vc1 : weight_vc0;
        if (state_q == ST_INIT) begin
            cur_vc_n = 1'b0;
            credit_n = '0;
        end else if (serve) begin
            if (!vc0_empty && !vc1_empty) begin
                pop_vc0 = !cur_vc;
                pop_vc1 = cur_vc;
                if (credit_inc == {1'b0, eff_weight(weight_cur)}) begin
                    cur_vc_n = !cur_vc;
                    credit_n = '0;
                end else begin
                    credit_n = credit_inc[W_WIDTH-1:0];
                end
            end else if (!vc0_empty) begin
                // Point at the other VC so a newcomer is served next.
                pop_vc0  = 1'b1;
                cur_vc_n = 1'b1;
                credit_n = '0;
            end else if (!vc1_empty) begin
                pop_vc1  = 1'b1;
                cur_vc_n = 1'b0;
                credit_n = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q    <= ST_RESET;
            valid_out  <= 1'b0;
            data_out   <= '0;
            cur_vc     <= 1'b0;
            credit     <= '0;
            weight_vc0 <= W_DEF;
            weight_vc1 <= W_DEF;
        end else begin
            state_q   <= state_n;
            cur_vc    <= cur_vc_n;
            credit    <= credit_n;
            // Output stage: popped head word appears one cycle after the pop.
            valid_out <= pop_vc0 | pop_vc1;
            if (pop_vc0)      data_out <= vc0_data;
            else if (pop_vc1) data_out <= vc1_data;
            if (state_q == ST_INIT) begin
                weight_vc0 <= cfg_weight_vc0;
                weight_vc1 <= cfg_weight_vc1;
            end
        end
    end

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
module tb_vc_wrr_scheduler;

    localparam int DW = 6;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          reset_L, init, vc0_empty, vc1_empty, pause_d0, pause_d1;
    logic [WW-1:0] cfg0, cfg1;
    logic [DW-1:0] vc0_data, vc1_data, data_out;
    logic          pop_vc0, pop_vc1, valid_out;
    logic [1:0]    state;

    always #5 clk = ~clk;

    vc_wrr_scheduler #(.DATA_WIDTH(DW), .W_WIDTH(WW), .W_DEFAULT(1)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .cfg_weight_vc0(cfg0), .cfg_weight_vc1(cfg1),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .pause_d0(pause_d0), .pause_d1(pause_d1),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .data_out(data_out), .valid_out(valid_out), .state(state)
    );

    // Bench-side show-ahead FIFOs feeding the DUT.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    int checks = 0;
    int errors = 0;

    // Reference model: scheduler state from the written rules.
    bit   m_known = 0;
    int   m_state = 0;
    bit   m_cur   = 0;
    int   m_credit = 0;
    int   m_w0 = 1;
    int   m_w1 = 1;
    bit   m_valid = 0;
    int   m_data = 0;
    logic d_p0, d_p1;

    typedef struct {
        bit            rst_n;
        bit            init;
        logic [WW-1:0] cfg0;
        logic [WW-1:0] cfg1;
        bit            pause;
        int            push0;
        int            push1;
        bit            chk_pop;
        int            exp_state;
        bit            exp_p0;
        bit            exp_p1;
        bit            exp_valid;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int weff(input int w);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic push(input int n0, input int n1);
        for (int k = 0; k < n0; k++) q0.push_back(DW'($urandom));
        for (int k = 0; k < n1; k++) q1.push_back(DW'($urandom));
    endtask

    // One clock: present FIFO heads, check pops, take the edge, check outputs.
    task automatic step();
        bit p0, p1, ne0, ne1, pz;
        int h0, h1;
        ne0 = (q0.size() > 0);
        ne1 = (q1.size() > 0);
        h0 = 0;
        h1 = 0;
        if (ne0) h0 = int'(q0[0]);
        if (ne1) h1 = int'(q1[0]);
        vc0_empty = !ne0;
        vc1_empty = !ne1;
        vc0_data  = DW'(h0);
        vc1_data  = DW'(h1);
        pz = pause_d0 | pause_d1;
        #1;
        p0 = 0;
        p1 = 0;
        if (m_known && m_state == 3 && !init && !pz) begin
            if (ne0 && ne1) begin
                if (m_cur) p1 = 1; else p0 = 1;
            end else if (ne0) p0 = 1;
            else if (ne1) p1 = 1;
        end
        d_p0 = pop_vc0;
        d_p1 = pop_vc1;
        if (m_known) begin
            chk("pop_vc0", pop_vc0, p0);
            chk("pop_vc1", pop_vc1, p1);
        end
        @(posedge clk);
        if (!reset_L) begin
            m_known = 1; m_state = 0; m_valid = 0; m_data = 0;
            m_cur = 0; m_credit = 0; m_w0 = 1; m_w1 = 1;
        end else if (m_known) begin
            m_valid = p0 | p1;
            if (p0) m_data = h0;
            else if (p1) m_data = h1;
            case (m_state)
                0: m_state = 1;
                1: begin
                    m_w0 = int'(cfg0); m_w1 = int'(cfg1);
                    m_cur = 0; m_credit = 0;
                    if (!init) m_state = 2;
                end
                2: begin
                    if (init) m_state = 1;
                    else if (ne0 || ne1) m_state = 3;
                end
                default: begin
                    if (init) m_state = 1;
                    else if (!pz) begin
                        if (ne0 && ne1) begin
                            m_credit++;
                            if (m_credit == weff(m_cur ? m_w1 : m_w0)) begin
                                m_cur = !m_cur;
                                m_credit = 0;
                            end
                        end else if (ne0) begin
                            m_cur = 1; m_credit = 0;
                        end else if (ne1) begin
                            m_cur = 0; m_credit = 0;
                        end else m_state = 2;
                    end
                end
            endcase
        end
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        #1;
        if (m_known) begin
            chk("state", state, m_state);
            chk("valid_out", valid_out, m_valid);
            chk("data_out", data_out, m_data);
        end
    endtask

    task automatic configure(input int w0, input int w1);
        cfg0 = WW'(w0);
        cfg1 = WW'(w1);
        init = 1;
        step();
        step();
        chk("cfg_in_init", state, 1);
        init = 0;
        step();
        chk("cfg_to_idle", state, 2);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q0.size() + q1.size()) > 0; i++) step();
        chk("drain_bound", q0.size() + q1.size(), 0);
        step();
        chk("drain_idle", state, 2);
        chk("drain_valid", valid_out, 0);
    endtask

    initial begin
        bit seq[12];
        reset_L = 0; init = 0; cfg0 = 0; cfg1 = 0; pause_d0 = 0; pause_d1 = 0;
        vc0_empty = 1; vc1_empty = 1; vc0_data = 0; vc1_data = 0;

        // rst init cfg0 cfg1 pause push0 push1 chk_pop exp_state p0 p1 valid
        tbl[0]  = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 4'd3, 4'd2, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[3]  = '{1, 0, 4'd3, 4'd2, 0, 0, 0, 1, 2, 0, 0, 0};
        tbl[4]  = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 2, 0, 0, 0};
        tbl[5]  = '{1, 0, 4'd0, 4'd0, 0, 4, 4, 1, 3, 0, 0, 0};
        tbl[6]  = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 3, 1, 0, 1};
        tbl[7]  = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 3, 1, 0, 1};
        tbl[8]  = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 3, 1, 0, 1};
        tbl[9]  = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 3, 0, 1, 1};
        tbl[10] = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 3, 0, 1, 1};
        tbl[11] = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 3, 1, 0, 1};
        tbl[12] = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 3, 0, 1, 1};
        tbl[13] = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 3, 0, 1, 1};
        tbl[14] = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 1, 2, 0, 0, 0};

        // Bring-up and weight 3/2 service from the vector table.
        for (int i = 0; i < 15; i++) begin
            reset_L  = tbl[i].rst_n;
            init     = tbl[i].init;
            cfg0     = tbl[i].cfg0;
            cfg1     = tbl[i].cfg1;
            pause_d1 = tbl[i].pause;
            push(tbl[i].push0, tbl[i].push1);
            step();
            if (tbl[i].chk_pop) begin
                chk($sformatf("tbl%0d_pop0", i), d_p0, tbl[i].exp_p0);
                chk($sformatf("tbl%0d_pop1", i), d_p1, tbl[i].exp_p1);
            end
            chk($sformatf("tbl%0d_state", i), state, tbl[i].exp_state);
            chk($sformatf("tbl%0d_valid", i), valid_out, tbl[i].exp_valid);
            if (!tbl[i].rst_n) chk($sformatf("tbl%0d_data", i), data_out, 0);
        end

        // Weighted service 2/1 with six words per VC.
        configure(2, 1);
        push(6, 6);
        step();
        seq = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("wrr_pop1_%0d", i), d_p1, seq[i]);
            chk($sformatf("wrr_pop0_%0d", i), d_p0, !seq[i]);
        end
        drain();

        // Pause mid-burst: credit and pointer hold across the pause.
        configure(2, 1);
        push(4, 4);
        step();
        step();
        chk("pause_first_vc0", d_p0, 1);
        pause_d1 = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pause_no_pop", {d_p0, d_p1}, 0);
            chk("pause_valid", valid_out, 0);
            chk("pause_state", state, 3);
        end
        pause_d1 = 0;
        step();
        chk("pause_resume_vc0", d_p0, 1);
        step();
        chk("pause_then_vc1", d_p1, 1);
        drain();

        // Single VC, then a late arrival on the other VC is served next.
        configure(1, 1);
        push(0, 3);
        step();
        step();
        chk("single_vc1_a", d_p1, 1);
        step();
        chk("single_vc1_b", d_p1, 1);
        push(1, 0);
        step();
        chk("arrival_vc0", d_p0, 1);
        drain();

        // Zero weights behave as weight one: strict alternation.
        configure(0, 0);
        push(4, 4);
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("zero_w_%0d", i), d_p1, (i % 2 == 1));
        end
        drain();

        // init during ACTIVE: no pop that cycle, then INIT.
        configure(1, 1);
        push(3, 3);
        step();
        step();
        init = 1;
        step();
        chk("init_no_pop", {d_p0, d_p1}, 0);
        chk("init_state", state, 1);
        init = 0;
        step();
        drain();

        // Reset mid-burst.
        push(3, 3);
        step();
        step();
        reset_L = 0;
        step();
        chk("midrst_state", state, 0);
        chk("midrst_valid", valid_out, 0);
        chk("midrst_data", data_out, 0);
        reset_L = 1;
        cfg0 = 1;
        cfg1 = 1;
        step();
        chk("midrst_init", state, 1);
        step();
        drain();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            reset_L  = ($urandom_range(0, 199) != 0);
            init     = ($urandom_range(0, 39) == 0);
            cfg0     = WW'($urandom);
            cfg1     = WW'($urandom);
            pause_d0 = ($urandom_range(0, 7) == 0);
            pause_d1 = ($urandom_range(0, 7) == 0);
            if (q0.size() < 6 && $urandom_range(0, 2) == 0) push(1, 0);
            if (q1.size() < 6 && $urandom_range(0, 2) == 0) push(0, 1);
            step();
            chk("pop_exclusive", d_p0 & d_p1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
